// File: rtl/gray_position_sequencer.sv
// gray_position_sequencer: round-robin shared position counter stepping at a prescaled rate,
// publishing registered binary and Gray copies of the position.
module gray_position_sequencer #(
    parameter int WIDTH    = 10,
    parameter int STEP_DIV = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req_a_i,
    input  logic             dir_a_i,
    input  logic [WIDTH-1:0] steps_a_i,
    input  logic             req_b_i,
    input  logic             dir_b_i,
    input  logic [WIDTH-1:0] steps_b_i,
    output logic             gnt_a_o,
    output logic             gnt_b_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             step_strobe_o,
    output logic [WIDTH-1:0] position_bin_o,
    output logic [WIDTH-1:0] position_gray_o
);
    localparam int DW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;

    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [WIDTH-1:0] rem_q, rem_d, pos_q, pos_d, gray_q, gray_d;
    logic             dir_q, dir_d, last_b_q, last_b_d;
    logic             gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d, strobe_q, strobe_d;
    logic             pick_a, pick_b, moving, step_now;

    // A wins a tie only when B was granted last
    assign pick_a   = req_a_i & (~req_b_i | last_b_q);
    assign pick_b   = req_b_i & ~pick_a;
    assign moving   = state_q == STEP && rem_q != '0;
    assign step_now = moving && div_q == DW'(STEP_DIV - 1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            div_q    <= '0;
            rem_q    <= '0;
            pos_q    <= '0;
            gray_q   <= '0;
            dir_q    <= 1'b0;
            last_b_q <= 1'b1;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            pos_q    <= pos_d;
            gray_q   <= gray_d;
            dir_q    <= dir_d;
            last_b_q <= last_b_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (pick_a | pick_b) ? STEP : IDLE;
            STEP:    state_d = rem_q == '0 ? DONE : STEP;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_d    = div_q;
        rem_d    = rem_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        last_b_d = last_b_q;
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
        strobe_d = 1'b0;
        if (state_q == IDLE && (pick_a | pick_b)) begin
            dir_d    = pick_a ? dir_a_i : dir_b_i;
            rem_d    = pick_a ? steps_a_i : steps_b_i;
            div_d    = '0;
            last_b_d = pick_b;
            gnt_a_d  = pick_a;
            gnt_b_d  = pick_b;
        end
        if (moving) begin
            div_d = step_now ? '0 : div_q + 1'b1;
        end
        if (step_now) begin
            pos_d    = dir_q ? pos_q + 1'b1 : pos_q - 1'b1;
            rem_d    = rem_q - 1'b1;
            strobe_d = 1'b1;
        end
        gray_d = pos_d ^ (pos_d >> 1);
    end

    always_comb begin
        busy_o          = state_q != IDLE;
        done_o          = state_q == DONE;
        gnt_a_o         = gnt_a_q;
        gnt_b_o         = gnt_b_q;
        step_strobe_o   = strobe_q;
        position_bin_o  = pos_q;
        position_gray_o = gray_q;
    end
endmodule

// File: tb/tb_gray_position_sequencer.sv
// tb_gray_position_sequencer: directed literal checks plus randomized moves compared every
// cycle against a move-level timing model of the sequencer.
module tb_gray_position_sequencer;
    localparam int W = 10, DIV = 4, M = 1 << W;

    logic         clk = 0, rst = 1;
    logic         req_a = 0, dir_a = 0, req_b = 0, dir_b = 0;
    logic [W-1:0] steps_a = 0, steps_b = 0;
    logic         gnt_a, gnt_b, busy, done, strobe;
    logic [W-1:0] bin, gray;
    int           vectors = 0, miscompares = 0;

    gray_position_sequencer #(.WIDTH(W), .STEP_DIV(DIV)) dut (
        .clk_i(clk), .reset_i(rst),
        .req_a_i(req_a), .dir_a_i(dir_a), .steps_a_i(steps_a),
        .req_b_i(req_b), .dir_b_i(dir_b), .steps_b_i(steps_b),
        .gnt_a_o(gnt_a), .gnt_b_o(gnt_b), .busy_o(busy), .done_o(done),
        .step_strobe_o(strobe), .position_bin_o(bin), .position_gray_o(gray)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Move-level model: a move granted at cycle s with n steps shows k = (c-s)/DIV steps
    // taken at cycle c, finishes with done at s+1+n*DIV, and the next idle cycle arbitrates.
    initial begin : cmp
        int  cyc, start, n, rel, k, pe, pos, p0, prev_gray;
        bit  valid, act, dir, winb, last_b, ea, eb, es, ed;
        valid = 0; act = 0; cyc = 0; start = 0; n = 0; pos = 0; p0 = 0;
        dir = 0; winb = 0; last_b = 1; prev_gray = 0;
        forever begin
            @(negedge clk);
            if (valid) begin
                if (act) begin
                    rel = cyc - start;
                    k   = rel / DIV;
                    if (k > n) k = n;
                    pe  = (p0 + M + (dir ? k : -k)) % M;
                    ea  = rel == 0 && !winb;
                    eb  = rel == 0 && winb;
                    es  = rel > 0 && rel % DIV == 0 && rel / DIV <= n;
                    ed  = rel == n * DIV + 1;
                end else begin
                    pe = pos; ea = 0; eb = 0; es = 0; ed = 0;
                end
                chk("busy", busy, act);
                chk("gnt_a", gnt_a, ea);
                chk("gnt_b", gnt_b, eb);
                chk("step_strobe", strobe, es);
                chk("done", done, ed);
                chk("position_bin", bin, pe);
                chk("position_gray", gray, pe ^ (pe >> 1));
                chk("gray_rule", gray, bin ^ (bin >> 1));
                if (strobe) chk("gray_1bit", $countones(gray ^ W'(prev_gray)), 1);
            end
            prev_gray = gray;
            if (rst) begin
                valid = 1; act = 0; last_b = 1; pos = 0;
            end else if (valid && act && cyc - start == n * DIV + 1) begin
                act = 0;
                pos = (p0 + M + (dir ? n : -n)) % M;
            end else if (valid && !act && (req_a || req_b)) begin
                winb   = req_b && !(req_a && last_b);
                act    = 1;
                start  = cyc + 1;
                p0     = pos;
                dir    = winb ? dir_b : dir_a;
                n      = winb ? steps_b : steps_a;
                last_b = winb;
            end
            cyc++;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; req_a = 0; req_b = 0;
        step(2);
        rst = 0;
    endtask

    initial begin
        int sum;
        // A alone, up 3 steps
        do_reset();
        req_a = 1; dir_a = 1; steps_a = 3;
        step();  chk("t1_gnt_a", gnt_a, 1); chk("t1_busy1", busy, 1); req_a = 0;
        step(4); chk("t1_pos5", bin, 1); chk("t1_gray5", gray, 1); chk("t1_strobe5", strobe, 1);
        step(4); chk("t1_pos9", bin, 2); chk("t1_gray9", gray, 3);
        step(4); chk("t1_pos13", bin, 3); chk("t1_gray13", gray, 2); chk("t1_done13", done, 0);
        step();  chk("t1_done14", done, 1); chk("t1_busy14", busy, 1);
        step();  chk("t1_busy15", busy, 0); chk("t1_done15", done, 0);
        // zero-step move leaves position alone
        req_a = 1; steps_a = 0;
        step();  chk("t4_gnt_a", gnt_a, 1); chk("t4_pos", bin, 3); req_a = 0;
        step();  chk("t4_done", done, 1); chk("t4_strobe", strobe, 0); chk("t4_pos2", bin, 3);
        // B down one step from 0 wraps
        do_reset();
        req_b = 1; dir_b = 0; steps_b = 1;
        step();  chk("t2_gnt_b", gnt_b, 1); req_b = 0;
        step(4); chk("t2_bin", bin, 'h3FF); chk("t2_gray", gray, 'h200); chk("t2_strobe", strobe, 1);
        step();  chk("t2_done", done, 1); chk("t2_strobe2", strobe, 0);
        // simultaneous requests alternate
        do_reset();
        req_a = 1; req_b = 1; dir_a = 1; dir_b = 1; steps_a = 0; steps_b = 0;
        step(); chk("t3_gnt_a1", gnt_a, 1); chk("t3_gnt_b1", gnt_b, 0); req_a = 0;
        step(); chk("t3_done1", done, 1); chk("t3_gnt_b_done", gnt_b, 0);
        step(); chk("t3_idle_gnt_b", gnt_b, 0);
        step(); chk("t3_gnt_b2", gnt_b, 1); req_a = 1;
        step(); chk("t3_done2_a", gnt_a, 0); chk("t3_done2_b", gnt_b, 0);
        step();
        step(); chk("t3_gnt_a3", gnt_a, 1); chk("t3_gnt_b3", gnt_b, 0); req_a = 0; req_b = 0;
        step(2);
        // reset mid-move
        do_reset();
        req_a = 1; dir_a = 1; steps_a = 5;
        step();  req_a = 0;
        step(4); chk("t5_pos5", bin, 1);
        step(2); rst = 1;
        step();  chk("t5_pos", bin, 0); chk("t5_busy", busy, 0); chk("t5_done", done, 0); rst = 0;
        step();  chk("t5_busy2", busy, 0); chk("t5_done2", done, 0);
        // random traffic
        do_reset();
        sum = 0;
        for (int i = 0; i < 10000; i++) begin
            step();
            if (gnt_a) begin sum += dir_a ? int'(steps_a) : -int'(steps_a); req_a = 0; end
            if (gnt_b) begin sum += dir_b ? int'(steps_b) : -int'(steps_b); req_b = 0; end
            if (!req_a) begin
                dir_a   = 1'($urandom);
                steps_a = $urandom_range(0, 39) == 0 ? W'($urandom) : W'($urandom_range(0, 16));
                req_a   = $urandom_range(0, 7) == 0;
            end
            if (!req_b) begin
                dir_b   = 1'($urandom);
                steps_b = $urandom_range(0, 39) == 0 ? W'($urandom) : W'($urandom_range(0, 16));
                req_b   = $urandom_range(0, 7) == 0;
            end
        end
        req_a = 0; req_b = 0;
        for (int t = 0; t < 5000 && busy; t++) step();
        chk("drain", busy, 0);
        chk("final_pos", bin, ((sum % M) + M) % M);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
